// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on request and result.
// Single-cycle ops finish on the accept edge. Unsigned multiply (shift-add)
// and unsigned divide (restoring) take WIDTH iterations of one bit each.
//
//  state  | meaning
//  IDLE   | waiting for a request; in_ready=1
//  CALC   | iterating multu/divu, one bit per cycle
//  DONE   | result valid, held until out_ready
module alu_mc #(
  parameter  int WIDTH = 32,
  localparam int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] C_hi,
  output logic             zero,
  output logic             ovf,
  output logic             div_by_zero
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_SRL   = 4'b0100;
  localparam logic [3:0] OP_SRA   = 4'b0101;
  localparam logic [3:0] OP_XOR   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SH_W-1:0]  cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] chi_q, chi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  logic             iter_in;
  logic             last_step;
  logic [WIDTH-1:0] alu_c;
  logic             alu_ovf;
  logic [WIDTH-1:0] sum, diff;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign iter_in   = (ALUOp == OP_MULTU) || (ALUOp == OP_DIVU);
  assign last_step = (cnt_q == SH_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a retiring result never overlaps a new accept
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = iter_in ? S_CALC : S_DONE;
      S_CALC: if (last_step) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and flag outputs; flags read as 0 unless a result is offered
  always_comb begin
    in_ready    = (state_q == S_IDLE);
    out_valid   = (state_q == S_DONE);
    C           = c_q;
    C_hi        = chi_q;
    zero        = out_valid & zero_q;
    ovf         = out_valid & ovf_q;
    div_by_zero = out_valid & dbz_q;
  end

  // Single-cycle ALU on the live request inputs
  always_comb begin
    sum     = A + B;
    diff    = A - B;
    shamt   = B[SH_W-1:0];
    alu_c   = '0;
    alu_ovf = 1'b0;
    case (ALUOp)
      OP_ADD: begin
        alu_c   = sum;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_c   = diff;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_c = A & B;
      OP_OR:   alu_c = A | B;
      OP_SRL:  alu_c = A >> shamt;
      OP_SRA:  alu_c = $unsigned($signed(A) >>> shamt);
      OP_XOR:  alu_c = A ^ B;
      OP_SLT:  alu_c = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: alu_c = '0;
    endcase
  end

  // One iteration of the shared multiply/divide engine.
  // Multiply: hi accumulates, lo holds the multiplier and collects product bits.
  // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
  // With B==0 every compare succeeds, giving all-ones quotient and remainder A.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_rem  = {hi_q, lo_q[WIDTH-1]};
    div_ge   = (div_rem >= {1'b0, b_q});
    div_diff = div_rem[WIDTH-1:0] - b_q;
    if (op_q == OP_DIVU) begin
      step_hi = div_ge ? div_diff : div_rem[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Datapath next-state: capture at accept, iterate in CALC, hold in DONE
  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    c_d    = c_q;
    chi_d  = chi_q;
    zero_d = zero_q;
    ovf_d  = ovf_q;
    dbz_d  = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = ALUOp;
          b_d   = B;
          cnt_d = '0;
          if (iter_in) begin
            hi_d = '0;
            lo_d = A;
          end else begin
            c_d    = alu_c;
            chi_d  = '0;
            zero_d = (alu_c == '0);
            ovf_d  = alu_ovf;
            dbz_d  = 1'b0;
          end
        end
      end
      S_CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + 1'b1;
        if (last_step) begin
          c_d    = step_lo;
          chi_d  = step_hi;
          zero_d = (step_lo == '0);
          ovf_d  = 1'b0;
          dbz_d  = (op_q == OP_DIVU) && (b_q == '0);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers, cleared by reset so an abandoned op leaves nothing behind
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      op_q   <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      c_q    <= '0;
      chi_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      b_q    <= b_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      c_q    <= c_d;
      chi_q  <= chi_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      dbz_q  <= dbz_d;
    end
  end

endmodule
